// File: rtl/audio_slot_scheduler.sv
// audio_slot_scheduler: time-slot scheduler that interleaves four 8-bit DAC
// sources in weighted slots per frame. Each source has a shadow config
// {en, weight} that is copied into the active set only at frame boundaries.
// Optional build macro: SCHED_FIXED_SLOTS_EN (all four sources always keep
// their slots in index order; disabled sources emit silent, invalid slots).
module audio_slot_scheduler (
   input  logic       clkdac,
   input  logic       rst_n,
   input  logic       cfg_we,
   input  logic [1:0] cfg_addr,
   input  logic [2:0] cfg_data,
   input  logic [7:0] src0,
   input  logic [7:0] src1,
   input  logic [7:0] src2,
   input  logic [7:0] src3,
   output logic [7:0] sample_out,
   output logic [1:0] src_sel,
   output logic       slot_valid,
   output logic       frame_start
);

   localparam int unsigned NSRC = 4;
   localparam int unsigned SW   = 8;
   localparam int unsigned IW   = 2;
   localparam int unsigned WW   = 2;

   typedef struct packed {
      logic          en;
      logic [WW-1:0] weight;
   } cfg_t;

   typedef enum logic {IDLE, RUN} state_t;

   localparam cfg_t CFG_RST = '{en: 1'b1, weight: '0};

   state_t               state_q, state_d;
   cfg_t [NSRC-1:0]      shadow_q;
   cfg_t [NSRC-1:0]      active_q, active_d;
   logic [IW-1:0]        cur_q, cur_d;
   logic [WW-1:0]        cnt_q, cnt_d;
   logic                 first_q, first_d;
   logic [SW-1:0]        sample_d;
   logic [IW-1:0]        sel_d;
   logic                 valid_d, fs_d;
   logic [SW-1:0]        src_cur;

`ifndef SCHED_FIXED_SLOTS_EN
   logic [IW:0]          nxt_pick;
   logic [IW:0]          new_pick;

   // Lowest enabled index >= start in a config set; MSB flags "found".
   function automatic logic [IW:0] pick_from(input cfg_t [NSRC-1:0] set,
                                             input int unsigned start);
      logic [IW:0] res;
      res = '0;
      for (int unsigned i = NSRC; i > 0; i--) begin
         if ((i - 1) >= start && set[i-1].en) res = {1'b1, IW'(i - 1)};
      end
      return res;
   endfunction

   // Candidate successors: next source in this frame, first of next frame.
   always_comb begin
      nxt_pick = pick_from(active_q, 32'(cur_q) + 32'd1);
      new_pick = pick_from(shadow_q, 32'd0);
   end
`endif

   // Sample mux for the source currently owning the slot.
   always_comb begin
      case (cur_q)
         2'd0:    src_cur = src0;
         2'd1:    src_cur = src1;
         2'd2:    src_cur = src2;
         default: src_cur = src3;
      endcase
   end

   // Next-state and output logic.
   always_comb begin
      state_d  = state_q;
      active_d = active_q;
      cur_d    = cur_q;
      cnt_d    = cnt_q;
      first_d  = 1'b0;
      sample_d = '0;
      sel_d    = src_sel;
      valid_d  = 1'b0;
      fs_d     = 1'b0;

      case (state_q)
         RUN: begin
            sel_d = cur_q;
            fs_d  = first_q;
`ifdef SCHED_FIXED_SLOTS_EN
            valid_d  = active_q[cur_q].en;
            sample_d = active_q[cur_q].en ? src_cur : '0;
            if (cnt_q != '0) begin
               cnt_d = WW'(cnt_q - WW'(1));
            end else if (cur_q != IW'(NSRC - 1)) begin
               cur_d = IW'(cur_q + IW'(1));
               cnt_d = active_q[IW'(cur_q + IW'(1))].weight;
            end else begin
               active_d = shadow_q;
               cur_d    = '0;
               cnt_d    = shadow_q[0].weight;
               first_d  = 1'b1;
            end
`else
            valid_d  = 1'b1;
            sample_d = src_cur;
            if (cnt_q != '0) begin
               cnt_d = WW'(cnt_q - WW'(1));
            end else if (nxt_pick[IW]) begin
               cur_d = nxt_pick[IW-1:0];
               cnt_d = active_q[nxt_pick[IW-1:0]].weight;
            end else begin
               active_d = shadow_q;
               if (new_pick[IW]) begin
                  cur_d   = new_pick[IW-1:0];
                  cnt_d   = shadow_q[new_pick[IW-1:0]].weight;
                  first_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
`endif
         end
         IDLE: begin
            active_d = shadow_q;
`ifdef SCHED_FIXED_SLOTS_EN
            state_d = RUN;
            cur_d   = '0;
            cnt_d   = shadow_q[0].weight;
            first_d = 1'b1;
`else
            if (new_pick[IW]) begin
               state_d = RUN;
               cur_d   = new_pick[IW-1:0];
               cnt_d   = shadow_q[new_pick[IW-1:0]].weight;
               first_d = 1'b1;
            end
`endif
         end
      endcase
   end

   // State, config and output registers.
   always_ff @(posedge clkdac or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         shadow_q    <= {NSRC{CFG_RST}};
         active_q    <= {NSRC{CFG_RST}};
         cur_q       <= '0;
         cnt_q       <= '0;
         first_q     <= 1'b1;
         sample_out  <= '0;
         src_sel     <= '0;
         slot_valid  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         cur_q       <= cur_d;
         cnt_q       <= cnt_d;
         first_q     <= first_d;
         sample_out  <= sample_d;
         src_sel     <= sel_d;
         slot_valid  <= valid_d;
         frame_start <= fs_d;
         if (cfg_we) shadow_q[cfg_addr] <= cfg_t'(cfg_data);
      end
   end

endmodule
